// File: rtl/usb_tx_packetizer.sv
`timescale 1ns/1ps
// usb_tx_packetizer: packs spectrum samples {4'hF, ctr, re, im} into fixed-size
// byte packets, buffers them in a small FIFO and streams them MSB-first to an
// FT2232H synchronous FIFO. A frame-final sample triggers a send-immediate pulse.
module usb_tx_packetizer #(
  parameter int unsigned CTR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned COMPLEX    = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_last_i,
  input  logic [CTR_WIDTH-1:0]  in_ctr_i,
  input  logic [DATA_WIDTH-1:0] in_re_i,
  input  logic [DATA_WIDTH-1:0] in_im_i,
  input  logic                  ft_txe_n_i,
  output logic                  ft_wr_n_o,
  output logic [7:0]            ft_data_o,
  output logic                  ft_siwua_n_o,
  output logic                  overflow_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o
);

  localparam int unsigned FieldBits = 4 + CTR_WIDTH + DATA_WIDTH * ((COMPLEX != 0) ? 2 : 1);
  localparam int unsigned PktBytes  = (FieldBits + 7) / 8;
  localparam int unsigned PktW      = PktBytes * 8;
  localparam int unsigned Pad       = PktW - FieldBits;
  localparam int unsigned AddrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW      = AddrW + 1;
  localparam int unsigned IdxW      = (PktBytes > 1) ? $clog2(PktBytes) : 1;

  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PktBytes - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StSend  = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  // Packet assembly: fields left-aligned, zero padding in the LSBs.
  logic [FieldBits-1:0] fields;
  logic [PktW-1:0]      pkt_in;

  if (COMPLEX != 0) begin : g_cplx
    assign fields = {4'hF, in_ctr_i, in_re_i, in_im_i};
  end else begin : g_real
    logic unused_im;
    assign fields    = {4'hF, in_ctr_i, in_re_i};
    assign unused_im = ^in_im_i;
  end

  assign pkt_in = PktW'(fields) << Pad;

  // FIFO bookkeeping
  logic [PktW:0]      mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic               in_ready_q;
  logic               push, pop, drop, empty, full;
  logic [PktW:0]      head;

  // FSM and shifter
  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [PktW-1:0]    shift_q, shift_d;
  logic               last_q, last_d;
  logic               xfer;

  // Output registers and drop accounting
  logic               ft_wr_n_q, ft_siwua_n_q, overflow_q;
  logic [7:0]         ft_data_q;
  logic [DROP_WIDTH-1:0] drop_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);
  // The registered ready flag decides acceptance, even if a pop frees a slot this cycle.
  assign push  = in_valid_i & in_ready_q;
  assign drop  = in_valid_i & ~in_ready_q & full;
  assign pop   = (state_q == StLoad);
  assign head  = mem_q[rd_ptr_q];
  assign xfer  = ~ft_wr_n_q & ~ft_txe_n_i;

  // Next FIFO occupancy
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Packet storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last_i, pkt_in};
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != DepthCnt);
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + DROP_WIDTH'(1);
    end
  end

  // FSM next state: load a packet, shift bytes out on accepted writes, optional flush
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StLoad;
      end
      StLoad: begin
        shift_d = head[PktW-1:0];
        last_d  = head[PktW];
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (xfer) begin
          if (idx_q == LastIdx) begin
            if (last_q)      state_d = StFlush;
            else if (!empty) state_d = StLoad;
            else             state_d = StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q << 8;
          end
        end
      end
      StFlush: begin
        state_d = empty ? StIdle : StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state plus registered FT2232H outputs derived from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      ft_wr_n_q    <= 1'b1;
      ft_siwua_n_q <= 1'b1;
      ft_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      ft_wr_n_q    <= (state_d != StSend);
      ft_siwua_n_q <= (state_d != StFlush);
      if (state_d == StSend) ft_data_q <= shift_d[PktW-1 -: 8];
    end
  end

  assign in_ready_o   = in_ready_q;
  assign ft_wr_n_o    = ft_wr_n_q;
  assign ft_data_o    = ft_data_q;
  assign ft_siwua_n_o = ft_siwua_n_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
`timescale 1ns/1ps
// Bench for usb_tx_packetizer: a byte-stream model built from the packet format
// checks every transferred byte and every flush pulse; directed checks pin timing.
module tb_usb_tx_packetizer;

  localparam int CW = 10;
  localparam int DW = 25;
  localparam int PB = 8;

  logic        clk = 1'b0;
  logic        rst;
  // default instance
  logic        in_valid, in_ready, in_last, txe_n, wr_n, siwua_n, overflow;
  logic [9:0]  in_ctr;
  logic [24:0] in_re, in_im;
  logic [7:0]  data;
  logic [15:0] drop_cnt;
  // real-only, shallow instance
  logic        r_valid, r_ready, r_last, r_txe_n, r_wr_n, r_siwua_n, r_overflow;
  logic [11:0] r_ctr;
  logic [15:0] r_re, r_im;
  logic [7:0]  r_data;
  logic [1:0]  r_drop;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q [$];
  bit         flg_q [$];
  bit         flush_due = 1'b0;

  always #5 clk = ~clk;

  usb_tx_packetizer u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_last_i(in_last), .in_ctr_i(in_ctr), .in_re_i(in_re), .in_im_i(in_im),
    .ft_txe_n_i(txe_n), .ft_wr_n_o(wr_n), .ft_data_o(data), .ft_siwua_n_o(siwua_n),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  usb_tx_packetizer #(
    .CTR_WIDTH(12), .DATA_WIDTH(16), .COMPLEX(0), .FIFO_DEPTH(2), .DROP_WIDTH(2)
  ) u_real (
    .clk_i(clk), .rst_i(rst), .in_valid_i(r_valid), .in_ready_o(r_ready),
    .in_last_i(r_last), .in_ctr_i(r_ctr), .in_re_i(r_re), .in_im_i(r_im),
    .ft_txe_n_i(r_txe_n), .ft_wr_n_o(r_wr_n), .ft_data_o(r_data),
    .ft_siwua_n_o(r_siwua_n), .overflow_o(r_overflow), .drop_cnt_o(r_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Packet built from the field list by plain shifting, then left-aligned to PB bytes.
  function automatic logic [63:0] model_pkt(input logic [9:0] c, input logic [24:0] re,
                                            input logic [24:0] im);
    logic [127:0] v;
    int nbits;
    nbits = 4 + CW + 2 * DW;
    v = 128'hF;
    v = (v << CW) | 128'(c);
    v = (v << DW) | 128'(re);
    v = (v << DW) | 128'(im);
    v = v << (PB * 8 - nbits);
    return v[63:0];
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] p, input int i);
    logic [63:0] s;
    s = p >> (8 * (PB - 1 - i));
    return s[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] c, input logic [24:0] re, input logic [24:0] im,
                      input bit last, input bit exp_acc);
    logic [63:0] p;
    in_valid = 1'b1; in_ctr = c; in_re = re; in_im = im; in_last = last;
    check("in_ready_at_push", in_ready, exp_acc);
    if (exp_acc) begin
      p = model_pkt(c, re, im);
      for (int i = 0; i < PB; i++) begin
        exp_q.push_back(byte_of(p, i));
        flg_q.push_back(last && (i == PB - 1));
      end
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_wr(input int max);
    for (int i = 0; i < max && wr_n; i++) tick();
    check("wr_n_low_in_time", wr_n, 1'b0);
  endtask

  // Compare process: every accepted write must match the model stream; flush pulses
  // must follow exactly the final byte of a last-flagged packet.
  initial begin
    logic [7:0] b;
    bit f;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (flush_due) begin
          check("flush_pulse", siwua_n, 1'b0);
          check("flush_wr_n", wr_n, 1'b1);
          flush_due = 1'b0;
        end else begin
          check("no_spurious_flush", siwua_n, 1'b1);
        end
        if (!wr_n && !txe_n) begin
          check("byte_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            f = flg_q.pop_front();
            check("stream_byte", data, b);
            if (f) flush_due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  lit41 [8];
    logic [7:0]  lit45 [4];
    logic [63:0] p;
    int          wr_cyc [$];
    int          sw_cyc [$];
    int          xfers, stall, cnt;

    lit41 = '{8'hFE, 8'h94, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    lit45 = '{8'hFA, 8'hBC, 8'h80, 8'h01};
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_ctr = '0; in_re = '0; in_im = '0;
    txe_n = 1'b0;
    r_valid = 1'b0; r_last = 1'b0; r_ctr = '0; r_re = '0; r_im = '0; r_txe_n = 1'b0;

    // Model pinned against hand-computed packets
    check("model_ref_041", model_pkt(10'h3A5, 25'd1, 25'd0), 64'hFE94_0000_0200_0000);
    check("model_ref_im_lsb", model_pkt(10'h000, 25'd0, 25'd1), 64'hF000_0000_0000_0001);

    // Reset values
    tick(); tick();
    check("rst_wr_n", wr_n, 1'b1);
    check("rst_siwua_n", siwua_n, 1'b1);
    check("rst_data", data, 8'h00);
    check("rst_ready", in_ready, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop", drop_cnt, 16'd0);
    rst = 1'b0;
    tick();
    check("ready_after_release", in_ready, 1'b1);

    // Single packet: latency N+2, 8 consecutive bytes, no flush
    push(10'h3A5, 25'd1, 25'd0, 1'b0, 1'b1);
    check("lat_n0_wr_n", wr_n, 1'b1);
    tick();
    check("lat_n1_wr_n", wr_n, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("single_wr_n", wr_n, 1'b0);
      check("single_byte", data, lit41[i]);
      check("single_siwua_n", siwua_n, 1'b1);
      tick();
    end
    check("single_done_wr_n", wr_n, 1'b1);
    repeat (3) tick();

    // Frame end: three packets, idle cycle between, flush after the last byte
    push(10'h001, 25'h1FFFFFF, 25'h0AAAAAA, 1'b0, 1'b1);
    push(10'h002, 25'h1000000, 25'h0000001, 1'b0, 1'b1);
    push(10'h3FF, 25'h0123456, 25'h1FEDCBA, 1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (!wr_n) wr_cyc.push_back(c);
      if (!siwua_n) sw_cyc.push_back(c);
      tick();
    end
    check("frame_writes", wr_cyc.size(), 24);
    check("frame_flushes", sw_cyc.size(), 1);
    if (wr_cyc.size() == 24 && sw_cyc.size() == 1) begin
      check("frame_period", wr_cyc[8] - wr_cyc[0], 9);
      check("frame_gap1", wr_cyc[8] - wr_cyc[7], 2);
      check("frame_gap2", wr_cyc[16] - wr_cyc[15], 2);
      check("frame_flush_pos", sw_cyc[0] - wr_cyc[23], 1);
    end

    // Backpressure during byte 3
    push(10'h155, 25'h1234567, 25'h0ABCDEF, 1'b0, 1'b1);
    p = model_pkt(10'h155, 25'h1234567, 25'h0ABCDEF);
    wait_wr(10);
    xfers = 0; stall = 0;
    for (int i = 0; i < 40; i++) begin
      if (xfers == 3 && stall < 5) begin
        txe_n = 1'b1;
        stall++;
        check("bp_hold_byte3", data, byte_of(p, 3));
        check("bp_hold_wr_n", wr_n, 1'b0);
      end else begin
        txe_n = 1'b0;
      end
      if (!wr_n && !txe_n) xfers++;
      tick();
    end
    txe_n = 1'b0;
    check("bp_total_bytes", xfers, 8);

    // Overflow: one packet parked in the shifter, then 20 pushes against 16 slots
    txe_n = 1'b1;
    push(10'h000, 25'd0, 25'd1, 1'b0, 1'b1);
    repeat (3) tick();
    check("ovf_head_wr_n", wr_n, 1'b0);
    check("ovf_head_byte0", data, 8'hF0);
    for (int k = 0; k < 20; k++) begin
      push(10'(k + 1), (k % 2 == 0) ? 25'd1 : 25'd0, (k % 2 == 0) ? 25'd0 : 25'd1, 1'b0,
           k < 16);
    end
    check("ovf_ready", in_ready, 1'b0);
    check("ovf_drop_cnt", drop_cnt, 16'd4);
    check("ovf_flag", overflow, 1'b1);
    txe_n = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check("ovf_drained", exp_q.size(), 0);
    repeat (3) tick();
    check("ovf_ready_after", in_ready, 1'b1);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_drop_kept", drop_cnt, 16'd4);

    // Reset at byte 5 of a packet
    push(10'h2C3, 25'h1555555, 25'h0F0F0F0, 1'b0, 1'b1);
    p = model_pkt(10'h2C3, 25'h1555555, 25'h0F0F0F0);
    wait_wr(10);
    repeat (5) tick();
    check("mid_byte5", data, byte_of(p, 5));
    rst = 1'b1;
    exp_q.delete(); flg_q.delete(); flush_due = 1'b0;
    tick();
    check("mid_rst_wr_n", wr_n, 1'b1);
    check("mid_rst_siwua_n", siwua_n, 1'b1);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_drop", drop_cnt, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_ready_after", in_ready, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wr_n) cnt++;
      tick();
    end
    check("mid_no_stale_writes", cnt, 0);

    // Real-only 4-byte packet with frame-end flush
    r_valid = 1'b1; r_ctr = 12'hABC; r_re = 16'h8001; r_im = 16'hFFFF; r_last = 1'b1;
    check("real_ready", r_ready, 1'b1);
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    for (int i = 0; i < 10 && r_wr_n; i++) tick();
    check("real_wr_n_low_in_time", r_wr_n, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("real_wr_n", r_wr_n, 1'b0);
      check("real_byte", r_data, lit45[i]);
      tick();
    end
    check("real_flush_siwua_n", r_siwua_n, 1'b0);
    check("real_flush_wr_n", r_wr_n, 1'b1);
    tick();
    check("real_flush_end", r_siwua_n, 1'b1);

    // Drop counter saturation on the 2-entry, 2-bit-counter instance
    r_txe_n = 1'b1;
    r_valid = 1'b1; r_re = 16'h0001;
    tick();
    r_valid = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 7; k++) begin
      r_valid = 1'b1; r_ctr = 12'(k);
      check("sat_ready", r_ready, k < 2);
      tick();
    end
    r_valid = 1'b0;
    check("sat_drop_cnt", r_drop, 2'd3);
    check("sat_overflow", r_overflow, 1'b1);
    check("sat_ready_end", r_ready, 1'b0);

    check("final_stream_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_tx_packetizer.md
USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001 Parameter CTR_WIDTH, default 10, meaning bin-index field width.
REQ-002 Parameter DATA_WIDTH, default 25, meaning width of each signed sample field.
REQ-003 Parameter COMPLEX, default 1, meaning 1 sends re and im fields, 0 sends re only.
REQ-004 Parameter FIFO_DEPTH, default 16, meaning packet FIFO entries; power of 2, ≥2.
REQ-005 Parameter DROP_WIDTH, default 16, meaning width of the drop counter.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  FT2232H 60 MHz clkout; all logic on rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 in_valid_i  in  1  sample present.
REQ-010 in_ready_o  out  1  sample accepted when in_valid_i & in_ready_o.
REQ-011 in_last_i  in  1  sample is final bin of a frame.
REQ-012 in_ctr_i  in  CTR_WIDTH  bin index.
REQ-013 in_re_i, in_im_i  in  DATA_WIDTH  sample fields; in_im_i ignored when COMPLEX=0.
REQ-014 ft_txe_n_i  in  1  low = FT2232H FIFO has room.
REQ-015 ft_wr_n_o  out  1  low = ft_data_o valid for write.
REQ-016 ft_data_o  out  8  byte to FT2232H; tristating is done outside this block.
REQ-017 ft_siwua_n_o  out  1  low pulse = send-immediate flush.
REQ-018 overflow_o  out  1  sticky: one or more samples dropped.
REQ-019 drop_cnt_o  out  DROP_WIDTH  saturating count of dropped samples.

Function
REQ-020 Packet SHALL be {4'hF, ctr, re, im (COMPLEX only)}, zero-padded at the LSB end to PKT_BYTES = ceil((4+CTR_WIDTH+DATA_WIDTH*(1+COMPLEX))/8); default PKT_BYTES = 8.
REQ-021 Bytes SHALL be sent MSB-first; byte 0 upper nibble is always 4'hF.
REQ-022 Accepted samples SHALL be stored as packed packets plus a last flag in a FIFO_DEPTH-entry FIFO.
REQ-023 in_ready_o SHALL be a registered signal equal to !full.
REQ-024 in_valid_i while full SHALL drop the sample, set overflow_o, and increment drop_cnt_o, which saturates at all-ones.
REQ-025 Simultaneous push and pop while full SHALL count as a drop; the ready flag is authoritative.
REQ-026 FSM states: IDLE, LOAD, SEND, FLUSH.
REQ-027 IDLE→LOAD: FIFO non-empty.
REQ-028 LOAD: pop head into the shift register and set the byte index to 0; the next state is SEND.
REQ-029 SEND: ft_wr_n_o=0, ft_data_o = current byte.
REQ-030 A byte SHALL transfer on an edge where ft_wr_n_o=0 and ft_txe_n_i=0; otherwise the byte is held unchanged.
REQ-031 After the transfer of byte PKT_BYTES-1, the next state SHALL be FLUSH if the packet's last flag is set, else LOAD if the FIFO is non-empty, else IDLE.
REQ-032 FLUSH SHALL hold ft_siwua_n_o=0 and ft_wr_n_o=1 for exactly one cycle, then go to LOAD or IDLE.
REQ-033 ft_wr_n_o, ft_data_o and ft_siwua_n_o SHALL be registered.
REQ-034 ft_wr_n_o SHALL be 1 in IDLE, LOAD and FLUSH.
REQ-035 Latency: with an empty FIFO, a sample accepted at edge N SHALL give byte 0 with ft_wr_n_o=0 after edge N+2.
REQ-036 Throughput SHALL be PKT_BYTES+1 cycles per packet with ft_txe_n_i held low.
REQ-037 ft_txe_n_i rising mid-packet SHALL stall without byte loss or duplication; it has no effect in other states.

Reset
REQ-038 Reset SHALL apply at any time, including mid-packet; the partial packet is discarded.
REQ-039 On reset: state IDLE, FIFO emptied, ft_wr_n_o=1, ft_siwua_n_o=1, ft_data_o=8'h00.
REQ-040 On reset: in_ready_o=0 during reset and 1 the cycle after release, overflow_o=0, drop_cnt_o=0.

Verification
REQ-041 Single packet: ctr=0x3A5, re=1, im=0, last=0, txe_n=0 -> bytes FE 94 00 00 02 00 00 00 on 8 consecutive write cycles, first at N+2; no siwua pulse.
REQ-042 Frame end: 3 samples, the third with last=1 -> 24 bytes written, one idle cycle between packets, one-cycle ft_siwua_n_o low after the final byte.
REQ-043 Backpressure: txe_n=1 for 5 cycles during byte 3 -> byte 3 held stable, ft_wr_n_o stays 0, exactly 8 bytes transferred in total.
REQ-044 Overflow: txe_n=1 permanently, 20 samples pushed with FIFO_DEPTH=16 -> 16 accepted, in_ready_o=0, drop_cnt_o=4, overflow_o=1; a sample whose single field bit is the LSB arrives as 1 in byte 7 / byte 4 (re) after txe_n goes low.
REQ-045 COMPLEX=0, CTR_WIDTH=12, DATA_WIDTH=16: PKT_BYTES=4; ctr=0xABC, re=0x8001 -> FA BC 80 01.
REQ-046 Reset asserted at byte 5 of a packet -> ft_wr_n_o=1 the next cycle, FIFO empty, counters zero, no stale bytes emitted afterward.
